// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op codes, FSM states and op classification shared by the multiply/divide unit
package muldiv_pkg;
    localparam logic [2:0] MULT  = 3'b000;
    localparam logic [2:0] MULTU = 3'b001;
    localparam logic [2:0] DIV   = 3'b010;
    localparam logic [2:0] DIVU  = 3'b011;
    localparam logic [2:0] MTHI  = 3'b100;
    localparam logic [2:0] MTLO  = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_e;

    function automatic logic is_iter(input logic [2:0] op);
        return op[2] == 1'b0;
    endfunction
endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one shift-add multiply step or one restoring-divide step on the {hi,lo} working pair
module muldiv_step #(
    parameter int N_BITS = 32
) (
    input  logic              div_i,
    input  logic [N_BITS-1:0] hi_i,
    input  logic [N_BITS-1:0] lo_i,
    input  logic [N_BITS-1:0] opnd_i,
    output logic [N_BITS-1:0] hi_o,
    output logic [N_BITS-1:0] lo_o
);
    logic [N_BITS:0] sum, shifted, diff;

    assign sum     = {1'b0, hi_i} + {1'b0, (lo_i[0] ? opnd_i : {N_BITS{1'b0}})};
    assign shifted = {hi_i, lo_i[N_BITS-1]};
    assign diff    = shifted - {1'b0, opnd_i};

    // mul: lo holds unconsumed multiplier bits and receives product bits from the top
    // div: lo shifts dividend bits out and quotient bits in
    always_comb begin
        hi_o = div_i ? (diff[N_BITS] ? shifted[N_BITS-1:0] : diff[N_BITS-1:0]) : sum[N_BITS:1];
        lo_o = div_i ? {lo_i[N_BITS-2:0], ~diff[N_BITS]} : {sum[0], lo_i[N_BITS-1:1]};
    end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU engine owning the HI/LO registers.
// MULDIV_FAST_MULT_EN selects a single-cycle combinational multiplier for MULT/MULTU.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int N_BITS = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_start,
    input  logic [2:0]        in_op_3,
    input  logic [N_BITS-1:0] in_A_32,
    input  logic [N_BITS-1:0] in_B_32,
    output logic              out_busy,
    output logic              out_done,
    output logic [N_BITS-1:0] out_HI_32,
    output logic [N_BITS-1:0] out_LO_32
);
    localparam int CW = $clog2(N_BITS);

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q;
    logic [N_BITS-1:0]   hi_q, lo_q, acc_hi_q, acc_lo_q, opnd_q, a_q;
    logic                div_q, b_zero_q, qneg_q, rneg_q, done_q;
    logic [N_BITS-1:0]   step_hi, step_lo, mag_a, mag_b;
    logic [2*N_BITS-1:0] init, acc, res;
    logic                issue, fast, is_div, a_neg, b_neg, mt_hi, mt_lo;

    assign is_div = in_op_3[1];
    assign a_neg  = !in_op_3[0] && in_A_32[N_BITS-1];
    assign b_neg  = !in_op_3[0] && in_B_32[N_BITS-1];
    assign mag_a  = a_neg ? -in_A_32 : in_A_32;
    assign mag_b  = b_neg ? -in_B_32 : in_B_32;
    assign issue  = state_q == IDLE && in_start && is_iter(in_op_3);
    assign mt_hi  = state_q == IDLE && in_start && in_op_3 == MTHI;
    assign mt_lo  = state_q == IDLE && in_start && in_op_3 == MTLO;

    muldiv_step #(.N_BITS(N_BITS)) u_step (
        .div_i  (div_q),
        .hi_i   (acc_hi_q),
        .lo_i   (acc_lo_q),
        .opnd_i (opnd_q),
        .hi_o   (step_hi),
        .lo_o   (step_lo)
    );

    always_comb begin
        init = {{N_BITS{1'b0}}, (is_div ? mag_a : mag_b)};
        fast = 1'b0;
`ifdef MULDIV_FAST_MULT_EN
        fast = !is_div;
        if (!is_div) init = {{N_BITS{1'b0}}, mag_a} * {{N_BITS{1'b0}}, mag_b};
`endif
    end

    // Magnitude result is sign-corrected here; divide-by-zero bypasses the datapath entirely
    always_comb begin
        acc = {acc_hi_q, acc_lo_q};
        res = div_q ? (b_zero_q ? {a_q, {N_BITS{1'b1}}}
                                : {(rneg_q ? -acc_hi_q : acc_hi_q), (qneg_q ? -acc_lo_q : acc_lo_q)})
                    : (qneg_q ? -acc : acc);
    end

    always_ff @(posedge clk) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = issue ? (fast ? FINISH : RUN) : IDLE;
            RUN:     state_d = cnt_q == CW'(N_BITS - 1) ? FINISH : RUN;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
`ifdef MULDIV_FAST_MULT_EN
        out_busy = state_q == RUN || (state_q == FINISH && !div_q);
`else
        out_busy = state_q == RUN;
`endif
        out_done  = done_q;
        out_HI_32 = hi_q;
        out_LO_32 = lo_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            opnd_q   <= '0;
            a_q      <= '0;
            div_q    <= 1'b0;
            b_zero_q <= 1'b0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= state_q == FINISH;
            cnt_q  <= state_q == RUN ? cnt_q + 1'b1 : '0;
            if (issue) begin
                div_q    <= is_div;
                a_q      <= in_A_32;
                b_zero_q <= in_B_32 == '0;
                qneg_q   <= a_neg ^ b_neg;
                rneg_q   <= a_neg;
                opnd_q   <= is_div ? mag_b : mag_a;
                acc_hi_q <= init[2*N_BITS-1:N_BITS];
                acc_lo_q <= init[N_BITS-1:0];
            end else if (state_q == RUN) begin
                acc_hi_q <= step_hi;
                acc_lo_q <= step_lo;
            end
            if (state_q == FINISH) begin
                hi_q <= res[2*N_BITS-1:N_BITS];
                lo_q <= res[N_BITS-1:0];
            end else begin
                if (mt_hi) hi_q <= in_A_32;
                if (mt_lo) lo_q <= in_A_32;
            end
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench; driver pushes expected HI/LO/latency, monitor checks on out_done
module tb_muldiv_unit;
    import muldiv_pkg::*;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          due;
        int          blen;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_start = 1'b0;
    logic [2:0]  in_op_3 = 3'b000;
    logic [31:0] in_A_32 = '0;
    logic [31:0] in_B_32 = '0;
    logic        out_busy, out_done;
    logic [31:0] out_HI_32, out_LO_32;

    exp_t sb[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   busy_run = 0;
    int   n_done = 0;
    int   n_exp = 0;

    muldiv_unit #(.N_BITS(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_start  (in_start),
        .in_op_3   (in_op_3),
        .in_A_32   (in_A_32),
        .in_B_32   (in_B_32),
        .out_busy  (out_busy),
        .out_done  (out_done),
        .out_HI_32 (out_HI_32),
        .out_LO_32 (out_LO_32)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!reset) busy_run = 0;
        else begin
            if (out_busy) busy_run++;
            if (out_done) begin
                n_done++;
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
                end else begin
                    e = sb.pop_front();
                    check({e.name, "_hi"}, out_HI_32, e.hi);
                    check({e.name, "_lo"}, out_LO_32, e.lo);
                    check({e.name, "_lat"}, cyc, e.due);
                    check({e.name, "_busy"}, busy_run, e.blen);
                    busy_run = 0;
                end
            end
        end
    end

    // poke > 0: pulse in_start with (pop, pa) at that negedge after issue, while the op is in flight
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] hi, input logic [31:0] lo, input string nm,
                          input int poke = 0, input logic [2:0] pop = MTHI, input logic [31:0] pa = 0);
        exp_t e;
        int   lat = 33;
        int   bl = 32;
`ifdef MULDIV_FAST_MULT_EN
        if (!op[1]) begin lat = 1; bl = 1; end
`endif
        @(negedge clk);
        in_start = 1'b1; in_op_3 = op; in_A_32 = a; in_B_32 = b;
        @(posedge clk);
        #1;
        in_start = 1'b0;
        e.hi = hi; e.lo = lo; e.due = cyc + lat; e.blen = bl; e.name = nm;
        sb.push_back(e);
        n_exp++;
        for (int i = 1; i < 100 && sb.size() != 0; i++) begin
            @(negedge clk);
            if (i == poke) begin
                in_start = 1'b1; in_op_3 = pop; in_A_32 = pa; in_B_32 = pa;
            end else in_start = 1'b0;
            #2;
        end
        in_start = 1'b0;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL %s_timeout: got %0d pending expected 0", nm, sb.size());
            sb.delete();
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_hi", out_HI_32, 32'h0);
        check("rst_lo", out_LO_32, 32'h0);
        check("rst_busy", {31'b0, out_busy}, 32'h0);
        check("rst_done", {31'b0, out_done}, 32'h0);
        reset = 1'b1;

        run_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max");
        run_op(MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_neg");
        run_op(MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, "mult_min");
        run_op(DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg");
        run_op(DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, "div_negb");
        run_op(DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        "divu");
        run_op(DIVU,  32'h1234,      32'd0,         32'h1234,      32'hFFFF_FFFF, "divu_zero");
        run_op(DIV,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, "div_zero");
        run_op(DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, "div_ovf");
        run_op(DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        "divu_poke_mthi", 4, MTHI, 32'hDEAD);
        run_op(DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        "divu_poke_div", 4, DIV, 32'd3);
        run_op(MULTU, 32'd3,         32'd5,         32'd0,         32'd15,        "multu_small");

        @(negedge clk);
        busy_run = 0;
        in_start = 1'b1; in_op_3 = MTHI; in_A_32 = 32'hCAFE;
        @(negedge clk);
        in_op_3 = MTLO; in_A_32 = 32'hBEEF;
        @(negedge clk);
        in_start = 1'b0;
        check("mt_hi", out_HI_32, 32'hCAFE);
        check("mt_lo", out_LO_32, 32'hBEEF);
        check("mt_busy", busy_run, 32'd0);
        @(negedge clk);
        in_start = 1'b1; in_op_3 = 3'b111; in_A_32 = 32'h5555;
        @(negedge clk);
        in_start = 1'b0;
        check("undef_hi", out_HI_32, 32'hCAFE);
        check("undef_lo", out_LO_32, 32'hBEEF);
        check("undef_busy", {31'b0, out_busy}, 32'h0);

        @(negedge clk);
        in_start = 1'b1; in_op_3 = MULT; in_A_32 = 32'd5; in_B_32 = 32'd7;
        @(negedge clk);
        in_start = 1'b0;
        repeat (3) @(negedge clk);
        in_start = 1'b1; in_op_3 = DIV; in_A_32 = 32'd9; in_B_32 = 32'd2;
        @(negedge clk);
        in_start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("abort_hi", out_HI_32, 32'h0);
        check("abort_lo", out_LO_32, 32'h0);
        check("abort_busy", {31'b0, out_busy}, 32'h0);
        repeat (40) @(negedge clk);
        check("done_count", n_done, n_exp);
        check("sb_empty", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
